// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 720p timing constants, scan-out modes and colour helpers
package vga_pkg;
    localparam int H_VISIBLE = 1280;
    localparam int H_TOTAL   = 1650;
    localparam int V_VISIBLE = 720;
    localparam int V_TOTAL   = 750;
    localparam int FB_W      = 320;
    localparam int BAR_W     = 160;

    typedef enum logic [1:0] {
        MODE_FB      = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SOLID   = 2'd3
    } scan_mode_t;

    function automatic logic [23:0] bar_colour(input logic [2:0] bar);
        case (bar)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Threshold compares instead of a divide by BAR_W; blanking positions clamp to the last bar.
    function automatic logic [2:0] bar_index(input logic [10:0] h);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= 11'(i * BAR_W)) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [23:0] expand_rgb332(input logic [7:0] i);
        return {i[7:5], i[7:5], i[7:6], i[4:2], i[4:2], i[4:3], {4{i[1:0]}}};
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - resettable fixed-depth shift register for pipeline alignment
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[DEPTH-1];
endmodule

// File: rtl/vga_scanout_pipe.sv
// rtl/vga_scanout_pipe.sv - 720p pixel stage: framebuffer fetch, test patterns, aligned RGB/sync output
module vga_scanout_pipe
    import vga_pkg::*;
#(
    parameter int FB_LAT = 1
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [10:0] h_counter,
    input  logic [9:0]  v_counter,
    input  logic        display_enable,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic [15:0] fb_addr,
    output logic        fb_rd_en,
    input  logic [7:0]  fb_rdata,
    output logic [23:0] rgb_out,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        frame_start
);
    localparam int A_W = 28;

    if (FB_LAT < 1 || FB_LAT > 4) begin : g_bad_fb_lat
        $fatal(1, "vga_scanout_pipe: FB_LAT=%0d outside 1..4", FB_LAT);
    end

    logic        frame_origin;
    logic        line_end;
    logic [9:0]  v_next;
    logic [7:0]  next_row;
    logic [15:0] line_base;
    scan_mode_t  mode_q;
    scan_mode_t  mode_eff;
    logic [23:0] solid_q;
    logic [23:0] solid_eff;
    logic [23:0] pattern;
    logic        de_a;
    scan_mode_t  mode_a;
    logic        fs_a;
    logic [23:0] pat_a;
    logic [A_W-1:0] a_bus;
    logic [A_W-1:0] a_late;
    logic        de_l;
    logic [1:0]  mode_l;
    logic        fs_l;
    logic [23:0] pat_l;
    logic [1:0]  sync_late;

    assign frame_origin = (h_counter == 11'd0) && (v_counter == 10'd0);
    assign line_end     = (h_counter == 11'(H_TOTAL - 1));
    assign v_next       = (v_counter == 10'(V_TOTAL - 1)) ? 10'd0 : v_counter + 10'd1;
    assign next_row     = v_next[9:2];

    // The first pixel of a frame already uses the mode sampled on that same cycle.
    assign mode_eff  = frame_origin ? scan_mode_t'(mode) : mode_q;
    assign solid_eff = frame_origin ? solid_rgb : solid_q;

    always_comb begin
        pattern = 24'h000000;
        case (mode_eff)
            MODE_BARS:    pattern = bar_colour(bar_index(h_counter));
            MODE_CHECKER: pattern = (h_counter[5] ^ v_counter[5]) ? 24'hFFFFFF : 24'h000000;
            MODE_SOLID:   pattern = solid_eff;
            default:      pattern = 24'h000000;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            line_base <= '0;
            mode_q    <= MODE_FB;
            solid_q   <= '0;
            fb_rd_en  <= 1'b0;
            fb_addr   <= '0;
            de_a      <= 1'b0;
            mode_a    <= MODE_FB;
            fs_a      <= 1'b0;
            pat_a     <= '0;
        end else begin
            // row * 320 as row*256 + row*64
            if (line_end) line_base <= ({8'd0, next_row} << 8) + ({8'd0, next_row} << 6);
            if (frame_origin) begin
                mode_q  <= scan_mode_t'(mode);
                solid_q <= solid_rgb;
            end
            fb_rd_en <= display_enable && (mode_eff == MODE_FB);
            fb_addr  <= line_base + {7'd0, h_counter[10:2]};
            de_a     <= display_enable;
            mode_a   <= mode_eff;
            fs_a     <= frame_origin;
            pat_a    <= pattern;
        end
    end

    assign a_bus = {de_a, mode_a, fs_a, pat_a};

    vga_delay_line #(.WIDTH(A_W), .DEPTH(FB_LAT)) u_stage_delay (
        .clk   (pixel_clk),
        .reset (reset),
        .d     (a_bus),
        .q     (a_late)
    );

    assign {de_l, mode_l, fs_l, pat_l} = a_late;

    // Syncs arrive one cycle late already, so they need one stage fewer than the data path.
    vga_delay_line #(.WIDTH(2), .DEPTH(FB_LAT + 1)) u_sync_delay (
        .clk   (pixel_clk),
        .reset (reset),
        .d     ({h_sync_in, v_sync_in}),
        .q     (sync_late)
    );

    assign h_sync_out = sync_late[1];
    assign v_sync_out = sync_late[0];

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rgb_out     <= '0;
            de_out      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de_out      <= de_l;
            frame_start <= fs_l;
            if (!de_l)                  rgb_out <= '0;
            else if (mode_l == MODE_FB) rgb_out <= expand_rgb332(fb_rdata);
            else                        rgb_out <= pat_l;
        end
    end
endmodule

// File: tb/tb_vga_scanout_pipe.sv
// tb/tb_vga_scanout_pipe.sv - self-checking bench for vga_scanout_pipe against a frame-level reference model
module tb_vga_scanout_pipe;
    localparam int LAT = 3;

    typedef struct {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
    } out_t;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic [10:0] h_counter;
    logic [9:0]  v_counter;
    logic        display_enable;
    logic        h_sync_in;
    logic        v_sync_in;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic [15:0] fb_addr;
    logic        fb_rd_en;
    logic [7:0]  fb_rdata;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        frame_start;

    logic [7:0]  fb_mem [65536];
    logic [7:0]  rdpipe [LAT];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    out_t        expq [$];
    out_t        zero_out = '{rgb: 24'h0, de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0};

    int          ch, cv, row, frame_mode, exp_addr;
    logic        exp_rden, prev_hs, prev_vs, rst_req;
    logic [1:0]  mode_req;
    logic [23:0] solid_req, frame_solid, s0;
    int          tests, fails;

    vga_scanout_pipe #(.FB_LAT(LAT)) dut (
        .pixel_clk      (pixel_clk),
        .reset          (reset),
        .h_counter      (h_counter),
        .v_counter      (v_counter),
        .display_enable (display_enable),
        .h_sync_in      (h_sync_in),
        .v_sync_in      (v_sync_in),
        .mode           (mode),
        .solid_rgb      (solid_rgb),
        .fb_addr        (fb_addr),
        .fb_rd_en       (fb_rd_en),
        .fb_rdata       (fb_rdata),
        .rgb_out        (rgb_out),
        .de_out         (de_out),
        .h_sync_out     (h_sync_out),
        .v_sync_out     (v_sync_out),
        .frame_start    (frame_start)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) begin
        rdpipe[0] <= fb_rd_en ? fb_mem[fb_addr] : 8'($urandom);
        for (int i = 1; i < LAT; i++) rdpipe[i] <= rdpipe[i-1];
    end
    assign fb_rdata = rdpipe[LAT-1];

    function automatic logic hs_of(input int h);
        return (h >= 1390) && (h < 1430);
    endfunction

    function automatic logic vs_of(input int v);
        return (v >= 725) && (v < 730);
    endfunction

    // RGB332 to RGB888 by bit replication, written as arithmetic.
    function automatic logic [23:0] expand(input logic [7:0] idx);
        int r3, g3, b2;
        r3 = idx / 32;
        g3 = (idx / 4) % 8;
        b2 = idx % 4;
        return {8'(r3 * 36 + r3 / 2), 8'(g3 * 36 + g3 / 2), 8'(b2 * 85)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One pixel clock: check outputs against the model, then present counter (ch,cv).
    task automatic step();
        out_t e;
        int   addr;
        logic de;
        @(negedge pixel_clk);
        e = expq.pop_front();
        chk("rgb_out", rgb_out, e.rgb);
        chk("de_out", de_out, e.de);
        chk("h_sync_out", h_sync_out, e.hs);
        chk("v_sync_out", v_sync_out, e.vs);
        chk("frame_start", frame_start, e.fs);
        chk("fb_rd_en", fb_rd_en, exp_rden);
        if (exp_rden) chk("fb_addr", fb_addr, exp_addr);

        de             = (ch < 1280) && (cv < 720);
        h_counter      = 11'(ch);
        v_counter      = 10'(cv);
        display_enable = de;
        h_sync_in      = prev_hs;
        v_sync_in      = prev_vs;
        reset          = rst_req;
        mode           = mode_req;
        solid_rgb      = solid_req;
        prev_hs        = hs_of(ch);
        prev_vs        = vs_of(cv);

        if (rst_req) begin
            foreach (expq[i]) expq[i] = zero_out;
            expq.push_back(zero_out);
            row = 0; frame_mode = 0; frame_solid = 0; exp_rden = 0; exp_addr = 0;
        end else begin
            if (ch == 0 && cv == 0) begin
                frame_mode  = mode_req;
                frame_solid = solid_req;
            end
            addr = row * 320 + ch / 4;
            e.de = de;
            e.hs = hs_of(ch);
            e.vs = vs_of(cv);
            e.fs = (ch == 0 && cv == 0);
            if (!de) e.rgb = 24'h0;
            else case (frame_mode)
                0:       e.rgb = expand(fb_mem[addr]);
                1:       e.rgb = bars[ch / 160];
                2:       e.rgb = (((ch / 32) % 2) != ((cv / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
                default: e.rgb = frame_solid;
            endcase
            expq.push_back(e);
            exp_rden = de && (frame_mode == 0);
            exp_addr = addr;
            if (ch == 1649) row = ((cv == 749) ? 0 : cv + 1) / 4;
        end

        ch++;
        if (ch == 1650) begin
            ch = 0;
            cv = (cv + 1) % 750;
        end
    endtask

    task automatic check_rgb_at(input int h, input int v, input logic [23:0] expv, input string tag);
        ch = h;
        cv = v;
        repeat (LAT + 2) step();
        @(posedge pixel_clk); #1;
        chk(tag, rgb_out, expv);
    endtask

    task automatic random_segments(input int n, input int len);
        for (int s = 0; s < n; s++) begin
            ch = $urandom_range(0, 1649);
            cv = $urandom_range(0, 749);
            repeat (len) step();
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; h_counter = '0; v_counter = '0; display_enable = 1'b0;
        h_sync_in = 1'b0; v_sync_in = 1'b0; mode = '0; solid_rgb = '0;
        rst_req = 1'b1; mode_req = 2'd0; solid_req = 24'h0;
        prev_hs = 1'b0; prev_vs = 1'b0;
        row = 0; frame_mode = 0; frame_solid = 0; exp_rden = 1'b0; exp_addr = 0;
        for (int i = 0; i < 65536; i++) fb_mem[i] = 8'($urandom);
        fb_mem[322] = 8'hE0;
        fb_mem[323] = 8'h03;
        fb_mem[324] = 8'h1C;
        repeat (LAT + 2) expq.push_back(zero_out);

        ch = 1645; cv = 749;
        repeat (4) step();
        @(posedge pixel_clk); #1;
        chk("reset_rgb", rgb_out, 0);
        chk("reset_de", de_out, 0);
        chk("reset_fs", frame_start, 0);
        chk("reset_rden", fb_rd_en, 0);
        chk("reset_addr", fb_addr, 0);
        rst_req = 1'b0;

        step();
        for (int i = 0; i < 8; i++) begin
            step();
            @(posedge pixel_clk); #1;
            chk("addr_line0", fb_addr, i / 4);
            chk("rden_line0", fb_rd_en, 1);
        end
        repeat (30) step();

        ch = 1640; cv = 3;
        repeat (10) step();
        step();
        @(posedge pixel_clk); #1;
        chk("addr_line4", fb_addr, 320);
        check_rgb_at(8, 4, 24'hFF0000, "idx_E0");
        check_rgb_at(12, 4, 24'h0000FF, "idx_03");
        check_rgb_at(16, 4, 24'h00FF00, "idx_1C");

        ch = 1645; cv = 718;
        repeat (5) step();
        step();
        @(posedge pixel_clk); #1;
        chk("addr_line719", fb_addr, 57280);
        repeat (20) step();
        ch = 1270; cv = 719;
        repeat (20) step();
        ch = 1380; cv = 726;
        repeat (60) step();
        random_segments(6, 150);

        mode_req = 2'd1;
        ch = 1645; cv = 749;
        repeat (20) step();
        check_rgb_at(0, 5, 24'hFFFFFF, "bar_white");
        check_rgb_at(160, 5, 24'hFFFF00, "bar_yellow");
        check_rgb_at(1279, 5, 24'h000000, "bar_black");
        random_segments(3, 100);

        mode_req = 2'd2;
        ch = 1645; cv = 749;
        repeat (20) step();
        check_rgb_at(32, 5, 24'hFFFFFF, "checker_on");
        check_rgb_at(32, 40, 24'h000000, "checker_off");
        random_segments(3, 100);

        mode_req = 2'd0;
        ch = 1645; cv = 749;
        repeat (10) step();
        ch = 630; cv = 300;
        repeat (10) step();
        mode_req = 2'd3;
        solid_req = 24'($urandom);
        repeat (20) step();
        step();
        @(posedge pixel_clk); #1;
        chk("mode_hold_rden", fb_rd_en, 1);
        ch = 1645; cv = 749;
        repeat (20) step();
        check_rgb_at(100, 0, solid_req, "solid");
        s0 = solid_req;
        solid_req = ~s0;
        check_rgb_at(200, 3, s0, "solid_hold");

        mode_req = 2'd0;
        ch = 1645; cv = 749;
        repeat (10) step();
        ch = 480; cv = 100;
        repeat (20) step();
        rst_req = 1'b1;
        repeat (10) step();
        rst_req = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge pixel_clk); #1;
            chk("flush_rgb", rgb_out, 0);
            chk("flush_de", de_out, 0);
            chk("flush_hs", h_sync_out, 0);
            chk("flush_vs", v_sync_out, 0);
            step();
        end
        while (!(cv == 101 && ch == 50)) step();
        step();
        @(posedge pixel_clk); #1;
        chk("addr_line101", fb_addr, 8012);

        random_segments(2, 100);
        repeat (LAT + 3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
